// File: rtl/vector_packer.sv
// Packs a scalar element stream into N-lane vectors; a nonzero end-of-frame tag closes a partial vector early, with the unused lanes zero-padded.
// Latency: valid_out is asserted in the cycle after the clock edge that accepts the closing element. Throughput is one element per cycle.
// Backpressure: none. Every element presented with in_valid is accepted.
module vector_packer #(
    parameter int N          = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [1:0]              in_eof,
    output logic [N*DATA_WIDTH-1:0] vector_out,
    output logic                    valid_out,
    output logic [1:0]              eof_out,
    output logic [15:0]             vec_count
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0][DATA_WIDTH-1:0] buf_q, buf_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic [N*DATA_WIDTH-1:0]      vec_q, vec_d;
    logic                         vld_q, vld_d;
    logic [1:0]                   eof_q, eof_d;
    logic [15:0]                  cnt_q, cnt_d;
    logic                         close;

    always_comb begin
        buf_d = buf_q;
        idx_d = idx_q;
        vec_d = vec_q;
        vld_d = 1'b0;
        eof_d = eof_q;
        cnt_d = cnt_q;
        close = in_valid && ((idx_q == IW'(N - 1)) || (in_eof != 2'b00));

        if (close) begin
            // The closing element bypasses the buffer straight into the output register.
            for (int k = 0; k < N; k++) begin
                if (k < int'(idx_q))
                    vec_d[k*DATA_WIDTH +: DATA_WIDTH] = buf_q[k];
                else if (k == int'(idx_q))
                    vec_d[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
                else
                    vec_d[k*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
            buf_d = '0;
            idx_d = '0;
            vld_d = 1'b1;
            eof_d = in_eof;
            cnt_d = cnt_q + 16'd1;
        end else if (in_valid) begin
            for (int k = 0; k < N; k++) begin
                if (k == int'(idx_q))
                    buf_d[k] = in_data;
            end
            idx_d = idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q <= '0;
            idx_q <= '0;
            vec_q <= '0;
            vld_q <= 1'b0;
            eof_q <= 2'b00;
            cnt_q <= 16'd0;
        end else begin
            buf_q <= buf_d;
            idx_q <= idx_d;
            vec_q <= vec_d;
            vld_q <= vld_d;
            eof_q <= eof_d;
            cnt_q <= cnt_d;
        end
    end

    assign vector_out = vec_q;
    assign valid_out  = vld_q;
    assign eof_out    = eof_q;
    assign vec_count  = cnt_q;

endmodule

// File: tb/tb_vector_packer.sv
// Bench for vector_packer: an N=4 instance driven by directed and random steps against a queue-based reference, plus an N=1 instance for counter wrap.
module tb_vector_packer;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [31:0]  in_data;
    logic [1:0]   in_eof;
    logic [127:0] vector_out;
    logic         valid_out;
    logic [1:0]   eof_out;
    logic [15:0]  vec_count;

    logic         in_valid1;
    logic [31:0]  in_data1;
    logic [1:0]   in_eof1;
    logic [31:0]  vector_out1;
    logic         valid_out1;
    logic [1:0]   eof_out1;
    logic [15:0]  vec_count1;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference: elements accepted since the last vector boundary, plus the last emitted vector.
    logic [31:0]  part[$];
    logic [127:0] m_vec = '0;
    logic [1:0]   m_eof = 2'b00;
    logic [15:0]  m_cnt = 16'd0;

    always #5 clk = ~clk;

    vector_packer #(.N(4), .DATA_WIDTH(32)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_eof(in_eof),
        .vector_out(vector_out), .valid_out(valid_out), .eof_out(eof_out), .vec_count(vec_count)
    );

    vector_packer #(.N(1), .DATA_WIDTH(32)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_data(in_data1), .in_eof(in_eof1),
        .vector_out(vector_out1), .valid_out(valid_out1), .eof_out(eof_out1), .vec_count(vec_count1)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one input cycle, advance the model, then check the outputs just after the edge.
    task automatic step(input string tag, input logic v, input logic [31:0] d, input logic [1:0] e);
        logic exp_vld;
        in_valid = v;
        in_data  = d;
        in_eof   = e;
        exp_vld  = 1'b0;
        if (v) begin
            part.push_back(d);
            if (part.size() == 4 || e != 2'b00) begin
                exp_vld = 1'b1;
                m_vec = '0;
                foreach (part[i]) m_vec[i*32 +: 32] = part[i];
                part.delete();
                m_eof = e;
                m_cnt = m_cnt + 16'd1;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_eof   = 2'b00;
        chk({tag, " valid_out"}, 128'(valid_out), 128'(exp_vld));
        chk({tag, " vector_out"}, vector_out, m_vec);
        chk({tag, " eof_out"}, 128'(eof_out), 128'(m_eof));
        chk({tag, " vec_count"}, 128'(vec_count), 128'(m_cnt));
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  e;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_eof    = 2'b00;
        in_valid1 = 1'b0;
        in_data1  = '0;
        in_eof1   = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid_out", 128'(valid_out), 128'(0));
        chk("reset vector_out", vector_out, 128'(0));
        chk("reset eof_out", 128'(eof_out), 128'(0));
        chk("reset vec_count", 128'(vec_count), 128'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Full vector, then continuous stream of three vectors.
        for (int i = 1; i <= 4; i++) step("full4", 1'b1, 32'(i), 2'b00);
        step("full4 after", 1'b0, 32'h0, 2'b00);
        for (int i = 0; i < 12; i++) step("stream", 1'b1, 32'(i), 2'b00);

        // Early close by eof, next element lands in lane 0.
        step("eof01", 1'b1, 32'hA, 2'b00);
        step("eof01", 1'b1, 32'hB, 2'b01);
        step("eof01 next", 1'b1, 32'hC, 2'b00);
        step("eof01 next", 1'b1, 32'hD, 2'b11);

        // Eof on the last lane emits once.
        for (int i = 5; i <= 8; i++) step("eoflast", 1'b1, 32'(i), (i == 8) ? 2'b10 : 2'b00);

        // Gap in the middle of a fill.
        step("gap", 1'b1, 32'd1, 2'b00);
        step("gap", 1'b1, 32'd2, 2'b00);
        for (int i = 0; i < 10; i++) step("gap idle", 1'b0, 32'hDEAD, 2'b01);
        step("gap", 1'b1, 32'd3, 2'b00);
        step("gap", 1'b1, 32'd4, 2'b00);

        // Eof on lane 0.
        step("eoflane0", 1'b1, 32'h77, 2'b11);

        // Asynchronous reset mid-fill.
        step("rst fill", 1'b1, 32'h11, 2'b00);
        step("rst fill", 1'b1, 32'h22, 2'b00);
        #3;
        reset = 1'b0;
        #1;
        part.delete();
        m_vec = '0;
        m_eof = 2'b00;
        m_cnt = 16'd0;
        chk("async rst valid_out", 128'(valid_out), 128'(0));
        chk("async rst vector_out", vector_out, 128'(0));
        chk("async rst eof_out", 128'(eof_out), 128'(0));
        chk("async rst vec_count", 128'(vec_count), 128'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post rst valid_out", 128'(valid_out), 128'(0));
        for (int i = 0; i < 4; i++) step("post rst", 1'b1, 32'd9, 2'b00);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            d = $urandom;
            e = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step("random", ($urandom_range(0, 9) < 7), d, e);
        end

        // Counter wrap on the single-lane build.
        in_valid1 = 1'b1;
        in_data1  = 32'h5A5A_0001;
        repeat (65535) @(posedge clk);
        #1;
        chk("n1 count ffff", 128'(vec_count1), 128'(16'hFFFF));
        chk("n1 valid_out", 128'(valid_out1), 128'(1));
        chk("n1 vector_out", 128'(vector_out1), 128'(32'h5A5A_0001));
        in_data1 = 32'hC0FF_EE00;
        in_eof1  = 2'b10;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        in_eof1   = 2'b00;
        chk("n1 count wrap", 128'(vec_count1), 128'(0));
        chk("n1 wrap vector_out", 128'(vector_out1), 128'(32'hC0FF_EE00));
        chk("n1 wrap eof_out", 128'(eof_out1), 128'(2'b10));
        @(posedge clk);
        #1;
        chk("n1 idle valid_out", 128'(valid_out1), 128'(0));
        chk("n1 hold vector_out", 128'(vector_out1), 128'(32'hC0FF_EE00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/vector_packer.md
# vector_packer

Upstream feeder for the debugger's vector input. Accepts a scalar element stream one DATA_WIDTH word per cycle, packs consecutive elements into N-lane vectors, and presents each completed vector with a one-cycle valid strobe and a 2-bit end-of-frame tag. These outputs drive the debugger's `vector_in`, `enqueue` and `eof_in` ports directly. Frame ends force early emission of a partial vector, zero-padded, so frame boundaries always coincide with vector boundaries.

## Interface
- N, 16, lanes per output vector (≥1)
- DATA_WIDTH, 32, bits per element
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  element present on in_data this cycle
- in_data  in  DATA_WIDTH  element value
- in_eof  in  2  end-of-frame tag on this element; 00 = none, any nonzero value closes the vector
- vector_out  out  N*DATA_WIDTH  packed vector, lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- valid_out  out  1  one-cycle strobe, vector_out/eof_out valid (to debugger enqueue)
- eof_out  out  2  tag of the emitted vector (to debugger eof_in)
- vec_count  out  16  number of vectors emitted since reset, wraps

## Operation
- Fill buffer: N lane registers, plus fill index `idx` (0..N-1, width clog2(N), min 1 bit).
- Accept: when in_valid=1, in_data is written to lane idx.
- Close condition: element accepted with idx==N-1 **or** in_eof!=00.
- On close:
  - Output registers load the buffer, including the current element. Lanes above idx are forced to 0.
  - eof_out ← in_eof.
  - valid_out pulses.
  - vec_count increments.
  - idx ← 0 and buffer lanes are cleared.
- Otherwise: idx ← idx+1, no output.
- in_valid=0: no state change, idx and partial buffer hold indefinitely.
- idx==N-1 together with in_eof!=00: exactly one vector emitted, eof_out=in_eof.
- N=1: every accepted element emits a vector.
- in_eof on lane 0 (idx==0): emits vector with lane 0 = in_data, all others 0.
- No backpressure. The consumer always accepts, so no element is ever dropped or stalled.
- Arithmetic:
  - vec_count is 16-bit unsigned, 0xFFFF+1 → 0x0000.
  - idx never exceeds N-1.
  - in_data is stored unmodified.

## Timing
- Reset (reset=0, asynchronous assert, synchronous-release):
  - valid_out=0, eof_out=00, vector_out=all 0, vec_count=0.
  - idx=0, buffer=0.
- Reset mid-fill discards the partial vector; no emission occurs for it.
- Latency: valid_out is high in the cycle after the clock edge that accepts the closing element (1-cycle registered latency).
- Output and fill buffer are separate registers. The element following a closing element may be accepted on the very next edge into lane 0. This gives sustained throughput of one element per cycle and one vector every N cycles.
- valid_out is high for exactly one cycle per vector.
- vector_out and eof_out hold their last emitted values until the next emission (not cleared when valid_out falls).
- No combinational path from any input to any output.

## Test plan
- N=4, DATA_WIDTH=32. Reset, then in_valid=1 for 4 cycles with data 1,2,3,4, in_eof=00.
  - Required: one cycle after 4th accept, valid_out=1, lanes {1,2,3,4}, eof_out=00, vec_count=1.
  - valid_out=0 on the following cycle.
- Continuous in_valid=1 with data 0..11.
  - Required: three strobes spaced exactly 4 cycles apart: {0,1,2,3}, {4,5,6,7}, {8,9,10,11}.
  - No gaps; vec_count=3.
- Data 0xA, 0xB with in_eof=01 on 0xB.
  - Required: vector {0xA,0xB,0,0}, eof_out=01.
  - Next element 0xC lands in lane 0.
- Data 5,6,7,8 with in_eof=10 on 8.
  - Required: a single vector {5,6,7,8}, eof_out=10, vec_count +1 (not +2).
- Data 1,2, then in_valid=0 for 10 cycles, then 3,4.
  - Required: no strobe during the gap; one vector {1,2,3,4}.
- Accept 2 elements, assert reset=0 asynchronously mid-cycle, release, then send 9,9,9,9.
  - Required: all outputs 0 immediately on assert.
  - First vector after release is {9,9,9,9}, vec_count=1.
- Additional: force vec_count to 0xFFFF via 65535 vectors (N=1 build), emit one more.
  - Required: vec_count=0x0000.
